// File: rtl/demux1to2_stream_pkg.sv
// Shared constants for the 1:2 stream demux: route-select encodings and default sizes.
package demux1to2_stream_pkg;
  localparam int   WIDTH_DEF = 4;
  localparam int   DEPTH_DEF = 2;
  localparam logic SEL_A     = 1'b0;
  localparam logic SEL_B     = 1'b1;
endpackage

// File: rtl/demux1to2_stream_fifo.sv
// Small synchronous FIFO, one per demux output. Head entry drives data_o directly;
// reset clears storage so the idle output reads zero.
module demux1to2_stream_fifo #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 2,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic             full_o,
  output logic             valid_o,
  output logic [WIDTH-1:0] data_o,
  output logic [CW-1:0]    count_o
);
  localparam int AW = $clog2(DEPTH);

  logic [DEPTH-1:0][WIDTH-1:0] mem_q;
  logic [AW-1:0]               wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]               count_q, count_d;
  logic                        do_push, do_pop;

  assign full_o  = (count_q == CW'(DEPTH));
  assign valid_o = (count_q != '0);
  assign data_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & valid_o;

  always_comb begin
    count_d = count_q;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // DEPTH is a power of two, so pointers wrap naturally.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= data_i;
        wr_ptr_q        <= wr_ptr_q + AW'(1);
      end
      if (do_pop) rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_d;
    end
  end
endmodule

// File: rtl/demux1to2_stream.sv
// Fans one input stream out to two buffered outputs under a per-beat select.
// in_ready depends only on the selected FIFO's full flag, never on the consumers' ready.
module demux1to2_stream
  import demux1to2_stream_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int DEPTH = DEPTH_DEF,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_sel,
  input  logic [WIDTH-1:0] in_data,
  output logic             a_valid,
  input  logic             a_ready,
  output logic [WIDTH-1:0] a_data,
  output logic [CW-1:0]    a_count,
  output logic             b_valid,
  input  logic             b_ready,
  output logic [WIDTH-1:0] b_data,
  output logic [CW-1:0]    b_count
);
  logic full_a, full_b, accept, push_a, push_b;

  assign in_ready = (in_sel == SEL_B) ? ~full_b : ~full_a;
  assign accept   = in_valid & in_ready;
  assign push_a   = accept & (in_sel == SEL_A);
  assign push_b   = accept & (in_sel == SEL_B);

  demux1to2_stream_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CW(CW)) u_fifo_a (
    .clk    (clk),
    .rst    (rst),
    .push_i (push_a),
    .data_i (in_data),
    .pop_i  (a_ready),
    .full_o (full_a),
    .valid_o(a_valid),
    .data_o (a_data),
    .count_o(a_count)
  );

  demux1to2_stream_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CW(CW)) u_fifo_b (
    .clk    (clk),
    .rst    (rst),
    .push_i (push_b),
    .data_i (in_data),
    .pop_i  (b_ready),
    .full_o (full_b),
    .valid_o(b_valid),
    .data_o (b_data),
    .count_o(b_count)
  );
endmodule

// File: tb/tb_demux1to2_stream.sv
// Directed and scoreboarded checks for demux1to2_stream (WIDTH=4, DEPTH=2).
module tb_demux1to2_stream;
  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid, in_ready, in_sel;
  logic [3:0] in_data;
  logic       a_valid, a_ready, b_valid, b_ready;
  logic [3:0] a_data, b_data;
  logic [1:0] a_count, b_count;

  int vecs = 0;
  int errs = 0;

  demux1to2_stream #(.WIDTH(4), .DEPTH(2), .CW(2)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_sel(in_sel), .in_data(in_data),
    .a_valid(a_valid), .a_ready(a_ready), .a_data(a_data), .a_count(a_count),
    .b_valid(b_valid), .b_ready(b_ready), .b_data(b_data), .b_count(b_count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0; in_valid = 1'b1; in_sel = 1'b0; in_data = 4'h7;
    a_ready = 1'b0; b_ready = 1'b0;
    tick();
    in_sel = 1'b1; in_data = 4'h9;
    tick();
    rst = 1'b1; in_valid = 1'b1; in_sel = 1'b0;
    tick(); tick();
    rst = 1'b0; in_valid = 1'b0;
    #1;
    vecs++; if ({a_valid, b_valid} !== 2'b00) begin errs++; $display("FAIL reset_valid got %b want 00", {a_valid, b_valid}); end
    vecs++; if ({a_count, b_count} !== 4'h0) begin errs++; $display("FAIL reset_count got %h want 0", {a_count, b_count}); end
    vecs++; if ({a_data, b_data} !== 8'h00) begin errs++; $display("FAIL reset_data got %h want 00", {a_data, b_data}); end
    in_sel = 1'b0; #1;
    vecs++; if (in_ready !== 1'b1) begin errs++; $display("FAIL reset_rdy_a got %b want 1", in_ready); end
    in_sel = 1'b1; #1;
    vecs++; if (in_ready !== 1'b1) begin errs++; $display("FAIL reset_rdy_b got %b want 1", in_ready); end
  endtask

  task automatic test_basic();
    a_ready = 1'b1; b_ready = 1'b1;
    in_valid = 1'b1; in_sel = 1'b0; in_data = 4'h5; #1;
    vecs++; if (in_ready !== 1'b1) begin errs++; $display("FAIL basic_rdy got %b want 1", in_ready); end
    tick();
    in_sel = 1'b1; in_data = 4'hA;
    vecs++; if ({a_valid, a_data} !== 5'h15) begin errs++; $display("FAIL basic_a got %b/%h want 1/5", a_valid, a_data); end
    vecs++; if (b_valid !== 1'b0) begin errs++; $display("FAIL basic_b_early got %b want 0", b_valid); end
    tick();
    in_valid = 1'b0;
    vecs++; if ({b_valid, b_data} !== 5'h1A) begin errs++; $display("FAIL basic_b got %b/%h want 1/a", b_valid, b_data); end
    vecs++; if (a_valid !== 1'b0) begin errs++; $display("FAIL basic_a_drained got %b want 0", a_valid); end
    tick();
    vecs++; if (b_valid !== 1'b0) begin errs++; $display("FAIL basic_b_drained got %b want 0", b_valid); end
  endtask

  task automatic test_full();
    a_ready = 1'b0; b_ready = 1'b0;
    in_valid = 1'b1; in_sel = 1'b0; in_data = 4'h1;
    tick();
    in_data = 4'h2;
    tick();
    vecs++; if (a_count !== 2'd2) begin errs++; $display("FAIL full_count got %0d want 2", a_count); end
    vecs++; if (a_data !== 4'h1) begin errs++; $display("FAIL full_head got %h want 1", a_data); end
    in_data = 4'h4; #1;
    vecs++; if (in_ready !== 1'b0) begin errs++; $display("FAIL full_rdy_a got %b want 0", in_ready); end
    in_sel = 1'b1; in_data = 4'h3; #1;
    vecs++; if (in_ready !== 1'b1) begin errs++; $display("FAIL full_rdy_b got %b want 1", in_ready); end
    tick();
    in_valid = 1'b0;
    vecs++; if ({b_count, b_data} !== 6'h13) begin errs++; $display("FAIL full_b_push got %0d/%h want 1/3", b_count, b_data); end
    vecs++; if (a_count !== 2'd2) begin errs++; $display("FAIL full_a_hold got %0d want 2", a_count); end
  endtask

  // A holds {1,2} from test_full, B holds {3}.
  task automatic test_push_pop_full();
    a_ready = 1'b1; in_valid = 1'b1; in_sel = 1'b0; in_data = 4'h4; #1;
    vecs++; if (in_ready !== 1'b0) begin errs++; $display("FAIL ppf_rdy got %b want 0", in_ready); end
    tick();
    vecs++; if ({a_count, a_data} !== 6'h12) begin errs++; $display("FAIL ppf_refused got %0d/%h want 1/2", a_count, a_data); end
    a_ready = 1'b0; #1;
    vecs++; if (in_ready !== 1'b1) begin errs++; $display("FAIL ppf_rdy_next got %b want 1", in_ready); end
    tick();
    in_valid = 1'b0;
    vecs++; if ({a_count, a_data} !== 6'h22) begin errs++; $display("FAIL ppf_accept got %0d/%h want 2/2", a_count, a_data); end
    a_ready = 1'b1; b_ready = 1'b1;
    tick();
    vecs++; if ({a_count, a_data} !== 6'h14) begin errs++; $display("FAIL ppf_drain got %0d/%h want 1/4", a_count, a_data); end
    vecs++; if (b_count !== 2'd0) begin errs++; $display("FAIL ppf_b_drain got %0d want 0", b_count); end
    tick();
    vecs++; if (a_valid !== 1'b0) begin errs++; $display("FAIL ppf_empty got %b want 0", a_valid); end
  endtask

  task automatic test_stream_b();
    int in_n = 0, out_n = 0;
    logic acc, stall;
    logic [3:0] held;
    a_ready = 1'b1;
    for (int cyc = 0; cyc < 200 && out_n < 16; cyc++) begin
      in_valid = (in_n < 16); in_sel = 1'b1; in_data = 4'(in_n);
      b_ready = cyc[0];
      #1;
      acc = in_valid & in_ready;
      if (b_valid && b_ready) begin
        vecs++;
        if (b_data !== 4'(out_n)) begin errs++; $display("FAIL stream_order got %h want %h", b_data, 4'(out_n)); end
        out_n++;
      end
      stall = b_valid & ~b_ready;
      held  = b_data;
      tick();
      if (acc) in_n++;
      if (stall) begin
        vecs++;
        if ({b_valid, b_data} !== {1'b1, held}) begin errs++; $display("FAIL stream_stall got %b/%h want 1/%h", b_valid, b_data, held); end
      end
    end
    in_valid = 1'b0;
    vecs++; if (out_n !== 16) begin errs++; $display("FAIL stream_count got %0d want 16", out_n); end
    vecs++; if (a_valid !== 1'b0) begin errs++; $display("FAIL stream_a_idle got %b want 0", a_valid); end
  endtask

  task automatic test_random();
    logic [3:0] qa[$], qb[$];
    int in_n = 0, out_n = 0, cyc = 0;
    logic acc, pa, pb, sel_s;
    logic [3:0] d_s;
    in_valid = 1'b0;
    while ((in_n < 10000 || qa.size() != 0 || qb.size() != 0) && cyc < 60000) begin
      if (!in_valid && in_n < 10000 && ($urandom_range(3) != 0)) begin
        in_valid = 1'b1; in_sel = 1'($urandom_range(1)); in_data = 4'($urandom_range(15));
      end
      a_ready = ($urandom_range(3) != 0);
      b_ready = ($urandom_range(3) != 0);
      #1;
      acc = in_valid & in_ready; sel_s = in_sel; d_s = in_data;
      pa = a_valid & a_ready; pb = b_valid & b_ready;
      if (pa) begin
        vecs++;
        if (qa.size() == 0 || a_data !== qa[0]) begin errs++; $display("FAIL rand_a got %h want %h", a_data, (qa.size() != 0) ? qa[0] : 4'hx); end
        if (qa.size() != 0) void'(qa.pop_front());
        out_n++;
      end
      if (pb) begin
        vecs++;
        if (qb.size() == 0 || b_data !== qb[0]) begin errs++; $display("FAIL rand_b got %h want %h", b_data, (qb.size() != 0) ? qb[0] : 4'hx); end
        if (qb.size() != 0) void'(qb.pop_front());
        out_n++;
      end
      tick();
      cyc++;
      if (acc) begin
        if (sel_s) qb.push_back(d_s); else qa.push_back(d_s);
        in_n++;
        in_valid = 1'b0;
      end
      vecs++;
      if (a_count !== 2'(qa.size()) || b_count !== 2'(qb.size())) begin
        errs++; $display("FAIL rand_count got %0d/%0d want %0d/%0d", a_count, b_count, qa.size(), qb.size());
      end
    end
    in_valid = 1'b0;
    vecs++; if (in_n !== 10000) begin errs++; $display("FAIL rand_in got %0d want 10000", in_n); end
    vecs++; if (out_n !== in_n) begin errs++; $display("FAIL rand_total got %0d want %0d", out_n, in_n); end
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_sel = 1'b0; in_data = 4'h0;
    a_ready = 1'b0; b_ready = 1'b0;
    tick(); tick();
    test_reset();
    test_basic();
    test_full();
    test_push_pop_full();
    test_stream_b();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
